// File: rtl/iseq_scheduler.sv
// iseq_scheduler
//   Shares the instruction-sequence dispatcher between host, auto-refresh and
//   periodic-read requesters. Arbitrates in IDLE (aref > prd > host, with a
//   host override after MAX_DEFER consecutive maintenance grants), steers the
//   FIFO input mux via src_sel, pulses process_iseq, follows dispatcher_busy
//   through its rise and fall, then acks the granted requester.
//
// Ports
//   clk, rst (async, active-low)
//   host_req/aref_req/prd_req   : pending requests (held until ack)
//   host_ack/aref_ack/prd_ack   : one-cycle completion pulses
//   src_sel[1:0]                : 0 host, 1 aref, 2 prd
//   process_iseq                : one-cycle dispatcher start pulse
//   dispatcher_busy             : dispatcher busy flag
//   periodic_read_lock          : high while a prd grant is active
//   sched_busy                  : high outside IDLE
//   timeout_err / err_clr       : sticky start-timeout flag and its clear
//   host_grants/aref_grants/prd_grants : saturating grant counters, present
//                                 only when ISEQ_SCHED_STATS_EN is defined
//
// All outputs are registered.
module iseq_scheduler #(
  parameter int MAX_DEFER     = 4,
  parameter int START_TIMEOUT = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_req,
  input  logic                 aref_req,
  input  logic                 prd_req,
  output logic                 host_ack,
  output logic                 aref_ack,
  output logic                 prd_ack,
  output logic [1:0]           src_sel,
  output logic                 process_iseq,
  input  logic                 dispatcher_busy,
  output logic                 periodic_read_lock,
  output logic                 sched_busy,
  output logic                 timeout_err,
  input  logic                 err_clr
`ifdef ISEQ_SCHED_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] host_grants,
  output logic [CNT_WIDTH-1:0] aref_grants,
  output logic [CNT_WIDTH-1:0] prd_grants
`endif
);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  localparam logic [1:0] SRC_HOST = 2'd0;
  localparam logic [1:0] SRC_AREF = 2'd1;
  localparam logic [1:0] SRC_PRD  = 2'd2;

  localparam int DW = $clog2(MAX_DEFER + 1);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [DW-1:0] DEFER_MAX    = DW'(MAX_DEFER);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(START_TIMEOUT);

  if (CNT_WIDTH < 1 || MAX_DEFER < 1 || START_TIMEOUT < 1) begin : g_bad_params
    $error("iseq_scheduler: CNT_WIDTH, MAX_DEFER and START_TIMEOUT must be >= 1");
  end

  state_t        state, state_n;
  logic [DW-1:0] defer_cnt, defer_cnt_n;
  logic [TW-1:0] start_cnt, start_cnt_n;
  logic [1:0]    src_sel_n;
  logic          process_iseq_n;
  logic [2:0]    ack_n;          // {prd, aref, host}
  logic          lock_n;
  logic          terr_n;
  logic          grant;
  logic [1:0]    grant_sel;

  function automatic logic [2:0] ack_for(input logic [1:0] sel);
    case (sel)
      SRC_AREF: ack_for = 3'b010;
      SRC_PRD:  ack_for = 3'b100;
      default:  ack_for = 3'b001;
    endcase
  endfunction

  // Arbitration; only meaningful in IDLE.
  always_comb begin
    grant     = 1'b0;
    grant_sel = SRC_HOST;
    if (state == IDLE) begin
      if (host_req && defer_cnt == DEFER_MAX) begin
        grant     = 1'b1;
        grant_sel = SRC_HOST;
      end else if (aref_req) begin
        grant     = 1'b1;
        grant_sel = SRC_AREF;
      end else if (prd_req) begin
        grant     = 1'b1;
        grant_sel = SRC_PRD;
      end else if (host_req) begin
        grant     = 1'b1;
        grant_sel = SRC_HOST;
      end
    end
  end

  always_comb begin
    state_n        = state;
    defer_cnt_n    = defer_cnt;
    start_cnt_n    = start_cnt;
    src_sel_n      = src_sel;
    process_iseq_n = 1'b0;
    ack_n          = 3'b000;
    lock_n         = periodic_read_lock;
    terr_n         = timeout_err;
    unique case (state)
      IDLE: begin
        if (err_clr) terr_n = 1'b0;
        if (grant) begin
          state_n        = START;
          src_sel_n      = grant_sel;
          process_iseq_n = 1'b1;
          lock_n         = (grant_sel == SRC_PRD);
          start_cnt_n    = TW'(1);
          if (grant_sel == SRC_HOST || !host_req)
            defer_cnt_n = '0;
          else if (defer_cnt != DEFER_MAX)
            defer_cnt_n = defer_cnt + 1'b1;
        end
      end
      START: begin
        if (dispatcher_busy) begin
          state_n = RUN;
        end else if (start_cnt == TIMEOUT_LAST) begin
          // A stalled dispatcher still completes the handshake so the
          // requester is not left waiting forever.
          terr_n  = 1'b1;
          state_n = DONE;
          ack_n   = ack_for(src_sel);
        end else begin
          start_cnt_n = start_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!dispatcher_busy) begin
          state_n = DONE;
          ack_n   = ack_for(src_sel);
        end
      end
      DONE: begin
        lock_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      defer_cnt          <= '0;
      start_cnt          <= '0;
      src_sel            <= SRC_HOST;
      process_iseq       <= 1'b0;
      host_ack           <= 1'b0;
      aref_ack           <= 1'b0;
      prd_ack            <= 1'b0;
      periodic_read_lock <= 1'b0;
      sched_busy         <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      state                         <= state_n;
      defer_cnt                     <= defer_cnt_n;
      start_cnt                     <= start_cnt_n;
      src_sel                       <= src_sel_n;
      process_iseq                  <= process_iseq_n;
      {prd_ack, aref_ack, host_ack} <= ack_n;
      periodic_read_lock            <= lock_n;
      sched_busy                    <= (state_n != IDLE);
      timeout_err                   <= terr_n;
    end
  end

`ifdef ISEQ_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      host_grants <= '0;
      aref_grants <= '0;
      prd_grants  <= '0;
    end else if (grant) begin
      case (grant_sel)
        SRC_AREF: if (aref_grants != '1) aref_grants <= aref_grants + 1'b1;
        SRC_PRD:  if (prd_grants  != '1) prd_grants  <= prd_grants  + 1'b1;
        default:  if (host_grants != '1) host_grants <= host_grants + 1'b1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_iseq_scheduler.sv
module tb_iseq_scheduler;
  localparam int MAX_DEFER     = 4;
  localparam int START_TIMEOUT = 16;
  localparam int CNT_WIDTH     = 16;

  logic clk = 1'b0;
  logic rst, host_req, aref_req, prd_req, busy, err_clr;
  logic host_ack, aref_ack, prd_ack, process_iseq, periodic_read_lock, sched_busy, timeout_err;
  logic [1:0] src_sel;
`ifdef ISEQ_SCHED_STATS_EN
  logic [CNT_WIDTH-1:0] host_grants, aref_grants, prd_grants;
`endif

  iseq_scheduler #(.MAX_DEFER(MAX_DEFER), .START_TIMEOUT(START_TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .aref_req(aref_req), .prd_req(prd_req),
    .host_ack(host_ack), .aref_ack(aref_ack), .prd_ack(prd_ack),
    .src_sel(src_sel), .process_iseq(process_iseq), .dispatcher_busy(busy),
    .periodic_read_lock(periodic_read_lock), .sched_busy(sched_busy),
    .timeout_err(timeout_err), .err_clr(err_clr)
`ifdef ISEQ_SCHED_STATS_EN
    , .host_grants(host_grants), .aref_grants(aref_grants), .prd_grants(prd_grants)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ack;   // {prd, aref, host}
    logic       terr;
  } ack_exp_t;

  int checks = 0;
  int failures = 0;
  logic [1:0] grant_q[$];
  ack_exp_t   ack_q[$];
  int cyc = 0;
  int dcnt = 0;
  bit disp_dead = 1'b0;
  int aref_left = 0;
  int lock_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_seq(input logic [1:0] src, input logic terr);
    ack_exp_t e;
    e.ack  = (src == 2'd1) ? 3'b010 : (src == 2'd2) ? 3'b100 : 3'b001;
    e.terr = terr;
    grant_q.push_back(src);
    ack_q.push_back(e);
  endtask

  // One clock: dispatcher model (busy rises 2 cycles after process_iseq,
  // stays up 10 cycles) and requesters dropping req on their ack.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) dcnt = 0;
    else if (process_iseq && !disp_dead) dcnt = 1;
    else if (dcnt != 0) dcnt = (dcnt == 12) ? 0 : dcnt + 1;
    busy = (dcnt >= 3);
    if (host_ack) host_req = 1'b0;
    if (aref_ack) begin
      aref_req = (aref_left > 0);
      if (aref_left > 0) aref_left--;
    end
    if (prd_ack) prd_req = 1'b0;
    if (periodic_read_lock) lock_cycles++;
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n = 0;
    tick();
    n++;
    while (!(grant_q.size() == 0 && ack_q.size() == 0 && !sched_busy) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drain"}, grant_q.size() + ack_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_host_ack"}, host_ack, 0);
    chk({tag, "_aref_ack"}, aref_ack, 0);
    chk({tag, "_prd_ack"}, prd_ack, 0);
    chk({tag, "_process_iseq"}, process_iseq, 0);
    chk({tag, "_lock"}, periodic_read_lock, 0);
    chk({tag, "_sched_busy"}, sched_busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_src_sel"}, src_sel, 0);
  endtask

  // Scoreboard monitor: pops on each grant pulse and each ack pulse.
  logic [1:0] mon_g;
  ack_exp_t   mon_a;
  always @(negedge clk) begin
    if (rst) begin
      if (process_iseq) begin
        if (grant_q.size() == 0) chk("unexpected_grant", process_iseq, 0);
        else begin
          mon_g = grant_q.pop_front();
          chk("grant_src", src_sel, mon_g);
          chk("grant_lock", periodic_read_lock, mon_g == 2'd2);
        end
      end
      if (host_ack || aref_ack || prd_ack) begin
        if (ack_q.size() == 0) chk("unexpected_ack", {prd_ack, aref_ack, host_ack}, 0);
        else begin
          mon_a = ack_q.pop_front();
          chk("ack_vec", {prd_ack, aref_ack, host_ack}, mon_a.ack);
          chk("ack_terr", timeout_err, mon_a.terr);
        end
      end
      if (periodic_read_lock) chk("lock_src", src_sel, 2);
    end
  end

  initial begin
    int n, pulses, fall, ackc, s_cyc, t_cyc;
    logic prevb;
    rst = 1'b1; host_req = 0; aref_req = 0; prd_req = 0; busy = 0; err_clr = 0;
    #2 rst = 1'b0;
    #1 check_zero("reset");
    tick(); tick();
    rst = 1'b1;
    tick();

    // Host alone: single start pulse, ack one cycle after busy falls.
    expect_seq(2'd0, 1'b0);
    host_req = 1'b1;
    n = 0; pulses = 0; fall = -100; ackc = -1; prevb = 1'b0;
    while (ackc < 0 && n < 60) begin
      tick();
      n++;
      if (process_iseq) pulses++;
      if (prevb && !busy) fall = cyc;
      prevb = busy;
      if (host_ack) ackc = cyc;
    end
    chk("s1_pulses", pulses, 1);
    chk("s1_ack_delay", ackc - fall, 1);
    run_until_idle(20, "s1");

    // All three together: aref, prd, host; lock spans the prd sequence only.
    expect_seq(2'd1, 1'b0);
    expect_seq(2'd2, 1'b0);
    expect_seq(2'd0, 1'b0);
    lock_cycles = 0;
    host_req = 1'b1; aref_req = 1'b1; prd_req = 1'b1;
    run_until_idle(100, "s2");
    chk("s2_lock_cycles", lock_cycles, 14);

    // Defer override: four arefs, host, then aref resumes.
    for (int i = 0; i < 4; i++) expect_seq(2'd1, 1'b0);
    expect_seq(2'd0, 1'b0);
    expect_seq(2'd1, 1'b0);
    aref_left = 4;
    host_req = 1'b1; aref_req = 1'b1;
    run_until_idle(200, "s3");

    // Start timeout: flag on the 16th START cycle, still acked, sticky until err_clr.
    disp_dead = 1'b1;
    expect_seq(2'd0, 1'b1);
    host_req = 1'b1;
    n = 0; s_cyc = -100; t_cyc = -1;
    while (t_cyc < 0 && n < 40) begin
      tick();
      n++;
      if (process_iseq) s_cyc = cyc;
      if (timeout_err) t_cyc = cyc;
    end
    chk("s4_timeout_cycle", t_cyc - s_cyc, START_TIMEOUT);
    run_until_idle(10, "s4");
    tick();
    chk("s4_err_sticky", timeout_err, 1);
    chk("s4_idle", sched_busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    chk("s4_err_clear", timeout_err, 0);
    disp_dead = 1'b0;

    // Reset during RUN of a prd sequence: everything drops, no ack; regrant after.
    expect_seq(2'd2, 1'b0);
    prd_req = 1'b1;
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    tick(); tick(); tick();
    chk("s5_lock_run", periodic_read_lock, 1);
    chk("s5_busy_run", sched_busy, 1);
    #2 rst = 1'b0;
    #1 check_zero("s5_rst");
    ack_q.delete();
    tick(); tick();
    rst = 1'b1;
    expect_seq(2'd2, 1'b0);
    run_until_idle(60, "s5");
    chk("s5_src_hold", src_sel, 2);
    chk("s5_lock_clear", periodic_read_lock, 0);

`ifdef ISEQ_SCHED_STATS_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    expect_seq(2'd1, 1'b0);
    expect_seq(2'd2, 1'b0);
    expect_seq(2'd0, 1'b0);
    host_req = 1'b1; aref_req = 1'b1; prd_req = 1'b1;
    run_until_idle(100, "s6a");
    expect_seq(2'd1, 1'b0);
    expect_seq(2'd0, 1'b0);
    host_req = 1'b1; aref_req = 1'b1;
    run_until_idle(100, "s6b");
    expect_seq(2'd0, 1'b0);
    host_req = 1'b1;
    run_until_idle(60, "s6c");
    chk("s6_host_grants", host_grants, 3);
    chk("s6_aref_grants", aref_grants, 2);
    chk("s6_prd_grants", prd_grants, 1);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iseq_scheduler.md
Name: iseq_scheduler

Overview:
- Shares the instruction-sequence dispatcher between three requesters: host instruction sequences, auto-refresh sequences and periodic-read sequences.
- Grants one requester at a time and drives src_sel to steer that source into the instr0/instr1 FIFOs.
- Pulses process_iseq, then tracks dispatcher_busy through its rise and fall, and acknowledges the requester when its sequence has drained.
- Sits between the host/maintenance instruction generators and iseq_dispatcher.

Parameters:
- MAX_DEFER, 4: consecutive maintenance grants allowed while host_req is pending; on the next arbitration the host wins.
- START_TIMEOUT, 16: cycles to wait for dispatcher_busy to rise after process_iseq before declaring a timeout.
- CNT_WIDTH, 16: width of the statistics counters (optional feature only).

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low (asserted at 0).
- host_req, in, 1: host sequence pending in its source buffer.
- aref_req, in, 1: auto-refresh sequence pending.
- prd_req, in, 1: periodic-read sequence pending.
- host_ack, out, 1: one-cycle pulse, host sequence completed.
- aref_ack, out, 1: one-cycle pulse, refresh sequence completed.
- prd_ack, out, 1: one-cycle pulse, periodic-read sequence completed.
- src_sel, out, 2: 0 = host, 1 = aref, 2 = prd; FIFO input mux select.
- process_iseq, out, 1: one-cycle start pulse to the dispatcher.
- dispatcher_busy, in, 1: busy flag from the dispatcher.
- periodic_read_lock, out, 1: high while a prd grant is active.
- sched_busy, out, 1: high in any state other than IDLE.
- timeout_err, out, 1: sticky flag, dispatcher failed to start.
- err_clr, in, 1: clears timeout_err.
- host_grants, out, CNT_WIDTH: statistics counter (optional feature only).
- aref_grants, out, CNT_WIDTH: statistics counter (optional feature only).
- prd_grants, out, CNT_WIDTH: statistics counter (optional feature only).

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE. All acks, process_iseq, periodic_read_lock, sched_busy and timeout_err are 0. src_sel = 0. Defer counter = 0. Statistics counters = 0. Reset mid-sequence abandons the grant; no ack is issued.
- All outputs are registered.
- States: IDLE, START, RUN, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - Priority is aref > prd > host.
  - Override: if host_req = 1 and defer_cnt = MAX_DEFER, the host wins.
  - On a grant: load src_sel, assert process_iseq for exactly one cycle (the first cycle of START), go to START.
  - periodic_read_lock is set on entry to START for a prd grant.
- START:
  - Counts cycles from 1.
  - dispatcher_busy = 1 -> RUN.
  - Count reaches START_TIMEOUT with busy still 0 -> set timeout_err, go to DONE.
- RUN: dispatcher_busy = 0 -> DONE.
- DONE:
  - Pulse the granted requester's ack for one cycle.
  - Clear periodic_read_lock.
  - Return to IDLE.
  - src_sel holds its value until the next grant.
- Request/ack rules:
  - A requester holds its req until its ack.
  - A req that drops before being granted is ignored.
  - A granted requester dropping its req mid-sequence does not abort the sequence.
  - The earliest possible new grant is the cycle after DONE: minimum 4 cycles grant-to-grant (START, RUN, DONE, IDLE).
- Defer counter:
  - A maintenance grant with host_req = 1: increment, saturating at MAX_DEFER.
  - A host grant: reset to 0.
  - A maintenance grant with host_req = 0: reset to 0.
- timeout_err:
  - Cleared by err_clr only while in IDLE.
  - A timeout set and an err_clr in the same cycle -> set wins.
- Simultaneous requests resolve in one cycle; there are no idle bubbles between arbitration and the grant.

Optional Feature:
- Macro: ISEQ_SCHED_STATS_EN.
- Defined:
  - host_grants, aref_grants and prd_grants each increment on their requester's grant (entry to START).
  - Counters saturate at all-ones and are cleared only by reset.
- Undefined:
  - The three counter ports are absent.
  - No counter logic is synthesized.

Test Plan:
- host_req = 1 only; dispatcher model raises busy 2 cycles after process_iseq and holds it 10 cycles -> src_sel = 0, a single process_iseq pulse, host_ack exactly 1 cycle after busy falls.
- aref_req, prd_req and host_req all asserted in the same cycle -> grant order aref, prd, host. periodic_read_lock is high only during the prd sequence.
- host_req held, aref_req re-asserted after every ack, MAX_DEFER = 4 -> four aref grants, then a host grant, then aref resumes.
- Dispatcher never raises busy, START_TIMEOUT = 16 -> timeout_err = 1 on cycle 16 of START, the requester is still acked, state returns to IDLE. A following err_clr pulse clears the flag.
- rst driven low during RUN of a prd sequence -> all outputs 0 immediately, no prd_ack. After release with prd_req still high -> new grant.
- With ISEQ_SCHED_STATS_EN defined: 3 host + 2 aref + 1 prd sequences -> host_grants = 3, aref_grants = 2, prd_grants = 1.
